// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding and index sizing helper,
// so every arbiter variant sizes its grant index the same way.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Width of a binary index able to address n requesters (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// uses the resource; the arbiter answers with a registered one-hot gnt, the
// binary gnt_id and gnt_valid. Ownership ends in the cycle the owner drops
// req[i]; gnt_id is meaningful only while gnt_valid is high.
interface rr_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = arb_pkg::idx_w(N)
);
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             gnt_valid;

  // Requester side
  modport master (output req, input gnt, input gnt_id, input gnt_valid);
  // Arbiter side
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid);
endinterface

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: lowest-index-first search over (req & mask)
// starting at ptr and wrapping through N-1 back to 0.
module rr_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = arb_pkg::idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] win_id_o,
  output logic             win_valid_o
);

  logic [N-1:0]     masked;
  logic [2*N-1:0]   dbl;
  logic [2*N-1:0]   dbl_shift;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] low_idx;
  logic [IDX_W:0]   sum;

  // Rotate right by ptr, pick the lowest set bit, rotate the index back.
  always_comb begin
    masked    = req_i & mask_i;
    dbl       = {masked, masked};
    dbl_shift = dbl >> ptr_i;
    rot       = dbl_shift[N-1:0];
    low_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) low_idx = IDX_W'(i);
    end
    sum = {1'b0, low_idx} + {1'b0, ptr_i};
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    win_id_o    = sum[IDX_W-1:0];
    win_valid_o = |masked;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary grant index and
// an optional hold-time limit that forces rotation under contention.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int IDX_W    = arb_pkg::idx_w(N),
  parameter int MAX_HOLD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_arbiter_if.slave        arb_if,
  output arb_state_t         dbg_state_o
);

  // hold_cnt is at least one bit wide even when the limit is disabled.
  localparam int HW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit HOLD_EN = (MAX_HOLD > 0);
  localparam logic [HW-1:0] HOLD_LAST = HOLD_EN ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [HW-1:0] HOLD_SAT  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [N-1:0]     enc_mask;
  logic             owner_req;
  logic             others_req;
  logic             force_rot;
  logic [IDX_W-1:0] win_id;
  logic             win_valid;

  // Detect forced rotation and mask the current owner out of the search.
  always_comb begin
    owner_req  = arb_if.req[gnt_id_q];
    others_req = |(arb_if.req & ~gnt_q);
    force_rot  = HOLD_EN && (state_q == ARB_GRANT) && owner_req &&
                 (hold_q == HOLD_LAST) && others_req;
    enc_mask   = force_rot ? ~gnt_q : '1;
  end

  rr_prio_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .req_i       (arb_if.req),
    .mask_i      (enc_mask),
    .ptr_i       (ptr_q),
    .win_id_o    (win_id),
    .win_valid_o (win_valid)
  );

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;

    case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d     = ARB_GRANT;
          gnt_d       = N'(1) << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
          ptr_d       = (win_id == LAST_IDX) ? '0 : win_id + 1'b1;
        end
      end
      ARB_GRANT: begin
        if (!owner_req || force_rot) begin
          // Release or forced rotation: hand over in the same cycle if
          // anyone else is waiting, otherwise fall back to idle.
          if (win_valid) begin
            gnt_d       = N'(1) << win_id;
            gnt_id_d    = win_id;
            gnt_valid_d = 1'b1;
            hold_d      = '0;
            ptr_d       = (win_id == LAST_IDX) ? '0 : win_id + 1'b1;
          end else begin
            state_d     = ARB_IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            hold_d      = '0;
          end
        end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
          // Lone owner at the limit keeps the grant; restart the count.
          hold_d = '0;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign arb_if.gnt       = gnt_q;
  assign arb_if.gnt_id    = gnt_id_q;
  assign arb_if.gnt_valid = gnt_valid_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: one instance without a hold limit and one
// with MAX_HOLD = 4. Inputs change and outputs are sampled on the falling edge.
module tb_rr_arbiter;
  import arb_pkg::*;

  logic clk;
  logic rst_n;
  arb_state_t st0, st4;
  int n_cmp;
  int n_err;

  rr_arbiter_if #(.N(8)) arb0 ();
  rr_arbiter_if #(.N(8)) arb4 ();

  rr_arbiter #(.N(8), .MAX_HOLD(0)) dut0 (
    .clk (clk), .rst_n (rst_n), .arb_if (arb0), .dbg_state_o (st0)
  );
  rr_arbiter #(.N(8), .MAX_HOLD(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .arb_if (arb4), .dbg_state_o (st4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    arb0.req = '0;
    arb4.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    arb0.req = 8'hFF;
    arb4.req = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (arb0.gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got %h exp 00", arb0.gnt); end
    n_cmp++; if (arb0.gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", arb0.gnt_valid); end
    n_cmp++; if (arb0.gnt_id !== 3'd0) begin n_err++; $display("FAIL reset_id got %0d exp 0", arb0.gnt_id); end
    n_cmp++; if (st0 !== ARB_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp IDLE", st0); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (arb0.gnt !== 8'h01) begin n_err++; $display("FAIL post_reset_gnt got %h exp 01", arb0.gnt); end
    n_cmp++; if (arb0.gnt_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_valid got %b exp 1", arb0.gnt_valid); end
    n_cmp++; if (st0 !== ARB_GRANT) begin n_err++; $display("FAIL post_reset_state got %0d exp GRANT", st0); end
    arb0.req = '0;
    @(negedge clk);
    n_cmp++; if (arb0.gnt !== 8'h00) begin n_err++; $display("FAIL release_idle got %h exp 00", arb0.gnt); end
  endtask

  task automatic test_single();
    arb0.req = 8'b0000_0100;
    @(negedge clk);
    n_cmp++; if (arb0.gnt !== 8'b0000_0100) begin n_err++; $display("FAIL single_gnt got %h exp 04", arb0.gnt); end
    n_cmp++; if (arb0.gnt_id !== 3'd2) begin n_err++; $display("FAIL single_id got %0d exp 2", arb0.gnt_id); end
    arb0.req = '0;
    @(negedge clk);
    n_cmp++; if (arb0.gnt !== 8'h00) begin n_err++; $display("FAIL single_drop got %h exp 00", arb0.gnt); end
    n_cmp++; if (arb0.gnt_valid !== 1'b0) begin n_err++; $display("FAIL single_drop_valid got %b exp 0", arb0.gnt_valid); end
  endtask

  task automatic test_fairness_wrap();
    logic [2:0] exp_id;
    logic [7:0] exp_gnt;
    do_reset();
    arb0.req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_id  = 3'(i % 8);
      exp_gnt = 8'h01 << exp_id;
      n_cmp++; if (arb0.gnt_valid !== 1'b1) begin n_err++; $display("FAIL fair_valid[%0d] got %b exp 1", i, arb0.gnt_valid); end
      n_cmp++; if (arb0.gnt_id !== exp_id) begin n_err++; $display("FAIL fair_id[%0d] got %0d exp %0d", i, arb0.gnt_id, exp_id); end
      n_cmp++; if (arb0.gnt !== exp_gnt) begin n_err++; $display("FAIL fair_gnt[%0d] got %h exp %h", i, arb0.gnt, exp_gnt); end
      // Owner drops its bit for one cycle; the previous owner re-raises.
      arb0.req = 8'hFF & ~exp_gnt;
    end
    arb0.req = '0;
    @(negedge clk);
    n_cmp++; if (arb0.gnt_valid !== 1'b0) begin n_err++; $display("FAIL fair_end_valid got %b exp 0", arb0.gnt_valid); end
  endtask

  task automatic test_forced_rotation();
    logic [7:0] exp_tab [12];
    exp_tab = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02,
                8'h01, 8'h01, 8'h01, 8'h01};
    do_reset();
    arb4.req = 8'h03;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++; if (arb4.gnt !== exp_tab[i]) begin n_err++; $display("FAIL rot_gnt[%0d] got %h exp %h", i, arb4.gnt, exp_tab[i]); end
    end
    arb4.req = '0;
    @(negedge clk);
    n_cmp++; if (arb4.gnt !== 8'h00) begin n_err++; $display("FAIL rot_end got %h exp 00", arb4.gnt); end
  endtask

  task automatic test_lone_owner();
    arb4.req = 8'h08;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_cmp++; if (arb4.gnt !== 8'h08) begin n_err++; $display("FAIL lone_gnt[%0d] got %h exp 08", i, arb4.gnt); end
      n_cmp++; if (arb4.gnt_id !== 3'd3) begin n_err++; $display("FAIL lone_id[%0d] got %0d exp 3", i, arb4.gnt_id); end
    end
    arb4.req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    arb0.req = 8'h20;
    @(negedge clk);
    n_cmp++; if (arb0.gnt !== 8'h20) begin n_err++; $display("FAIL mid_pre got %h exp 20", arb0.gnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (arb0.gnt !== 8'h00) begin n_err++; $display("FAIL mid_async_gnt got %h exp 00", arb0.gnt); end
    n_cmp++; if (arb0.gnt_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b exp 0", arb0.gnt_valid); end
    arb0.req = 8'h21;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (arb0.gnt !== 8'h01) begin n_err++; $display("FAIL mid_regrant got %h exp 01", arb0.gnt); end
    n_cmp++; if (arb0.gnt_id !== 3'd0) begin n_err++; $display("FAIL mid_regrant_id got %0d exp 0", arb0.gnt_id); end
    arb0.req = '0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    arb0.req = '0;
    arb4.req = '0;
    test_reset();
    test_single();
    test_fairness_wrap();
    test_forced_rotation();
    test_lone_owner();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one resource among `N` requesters. It issues a registered one-hot grant plus a binary grant index. The grant is held until the owner releases it or a hold-time limit forces rotation. It builds on the lowest-index-first priority encoding used by our combinational encoders: a rotating pointer turns the fixed priority into a fair one. It sits in front of any single-ported shared datapath, for example a shared bus, ALU or memory port.

## Interface
- `N`, 8: number of requesters; must be ≥ 2.
- `IDX_W`, `$clog2(N)` (3 for N = 8): width of the grant index.
- `MAX_HOLD`, 0: maximum consecutive cycles one owner keeps the grant while others wait. 0 disables the limit.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N: request vector. A requester holds its bit high for as long as it uses the resource.
- `gnt` output N: one-hot grant; all zero when nobody owns the resource.
- `gnt_id` output IDX_W: binary index of the owner; valid only while `gnt_valid` = 1.
- `gnt_valid` output 1: high when exactly one bit of `gnt` is set.

## Operation
- State machine, two states:
  - `ARB_IDLE`: no owner; `gnt` = 0.
  - `ARB_GRANT`: one owner.
- Pointer `ptr` (IDX_W bits): the search for a new owner starts at index `ptr` and wraps through N-1 to 0. The first requesting index in that order wins.
- When a new grant is issued to index k, `ptr` is updated to (k+1) mod N. Wrap from N-1 back to 0 is required.
- `ARB_IDLE` with `req` ≠ 0: grant to the winner, go to `ARB_GRANT`, clear `hold_cnt`.
- `ARB_GRANT` while `req[gnt_id]` = 1 and the hold limit has not expired: keep the grant and increment `hold_cnt`, saturating.
- `ARB_GRANT` while `req[gnt_id]` = 0 (release):
  - Re-arbitrate among the remaining requests in the same cycle.
  - If any remain, grant the winner directly, with no idle cycle.
  - If none remain, go to `ARB_IDLE`.
- Forced rotation (`MAX_HOLD` > 0):
  - Triggers when `hold_cnt` = MAX_HOLD-1 and at least one other bit of `req` is high.
  - The next owner is chosen with the current owner masked out.
  - If the owner is the only requester, it keeps the grant and `hold_cnt` restarts at 0.
- Simultaneous release and a new request from the same index: the index is treated as a new requester. It is searched from the updated `ptr`, so it loses to any other pending request.
- `hold_cnt` width is `$clog2(MAX_HOLD+1)`, minimum 1 bit, and it never wraps.
- Reset values, applied asynchronously on `rst_n` = 0 at any time, including mid-grant:
  - `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0
  - `ptr` = 0, `hold_cnt` = 0, state = `ARB_IDLE`
  - After reset the resource must be re-requested.

## Timing
- All outputs are registered. There is no combinational path from `req` to `gnt`.
- Grant latency: `req` high in cycle t, sampled at the edge ending cycle t, gives `gnt` in cycle t+1.
- Handover latency: owner drops `req` in cycle t; the next owner's `gnt` appears in cycle t+1. The old owner's `gnt` bit is low in cycle t+1.
- The owner must not drop `req` before it sees `gnt`. A request that drops before being granted is simply not served.
- Forced rotation: with `MAX_HOLD` = M, an owner facing contention holds `gnt` for exactly M cycles.
- At most one `gnt` bit is high in any cycle.

## Structure
- Shared package `arb_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;`
  - a shared `idx_w(n)` function so sibling arbiters size their indices identically.
- Sub-module `rr_prio_enc` (N, IDX_W):
  - Combinational and parameterised.
  - Rotates `req & mask` right by `ptr`, finds the lowest set bit, and rotates the index back.
  - Outputs `win_id` and `win_valid`.
- `rr_arbiter` holds the state register, `ptr`, `hold_cnt` and the output registers.

## Test plan
- Reset: `rst_n` = 0 with `req` = 8'hFF → `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0. After release of reset, `gnt` = 8'h01 one cycle later.
- Single requester: `req` = 8'b0000_0100 → `gnt` = 8'b0000_0100, `gnt_id` = 2 in the next cycle. Dropping `req` → `gnt` = 0 in the cycle after.
- Fairness and wrap: `req` = 8'hFF, each owner drops its bit for one cycle after being granted, then re-raises it → `gnt_id` sequence 0,1,2,…,7,0,1 with no idle cycles.
- Forced rotation with `MAX_HOLD` = 4 and `req` = 8'h03 held constant → `gnt` = 8'h01 for 4 cycles, then 8'h02 for 4 cycles, then 8'h01 again.
- Lone owner at limit with `MAX_HOLD` = 4 and `req` = 8'h08 → `gnt` = 8'h08 continuously for at least 12 cycles, with no glitch.
- Reset mid-operation: assert `rst_n` = 0 asynchronously while `gnt` = 8'h20 → `gnt` = 0 before the next edge. After release with `req` = 8'h21, the first grant is 8'h01 because `ptr` was reset to 0.
